// File: rtl/bus_pkg.sv
// Shared types for the 8085-style bus cycle arbiter: one-hot cycle phases,
// strobe idle levels and the latched cycle type.
package bus_pkg;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_T1      = 6'b000010,
        ST_T2      = 6'b000100,
        ST_TW      = 6'b001000,
        ST_T3      = 6'b010000,
        ST_RELEASE = 6'b100000
    } bus_state_t;

    localparam logic STROBE_OFF = 1'b1;
    localparam logic ALE_OFF    = 1'b0;

    typedef struct packed {
        logic iom;
        logic we;
    } cyc_type_t;

    // T2, TW and T3 are the phases in which the selected strobe is driven
    function automatic logic is_strobe_state(input bus_state_t s);
        return (s == ST_T2) || (s == ST_TW) || (s == ST_T3);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping modulo NUM_REQ. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] gnt_next_o,
    output logic [IDX_W-1:0]   winner_o
);

    int               sum_s;
    logic [IDX_W-1:0] sel_s;
    logic             found_s;
    logic             hit_s;

    // Scan requesters starting at the pointer; the first hit wins
    always_comb begin
        gnt_next_o = '0;
        winner_o   = '0;
        found_s    = 1'b0;
        hit_s      = 1'b0;
        sum_s      = 0;
        sel_s      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum_s = int'(ptr_i) + off;
            sel_s = (sum_s >= NUM_REQ) ? IDX_W'(sum_s - NUM_REQ) : IDX_W'(sum_s);
            hit_s = enable_i & ~found_s & req_i[sel_s];
            gnt_next_o[sel_s] = gnt_next_o[sel_s] | hit_s;
            winner_o = hit_s ? sel_s : winner_o;
            found_s  = found_s | hit_s;
        end
    end

endmodule

// File: rtl/bus_cycle_arbiter.sv
// Round-robin owner of one 8085-style peripheral bus; sequences each granted
// transfer T1 (ALE) -> T2 -> TW* -> T3 -> RELEASE with registered bus outputs.
module bus_cycle_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ-1:0]        iom,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ALE,
    output logic                      rdb,
    output logic                      wrb,
    output logic                      IOM,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W-1:0]         bus_dout,
    output logic                      bus_doe,
    input  logic [DATA_W-1:0]         bus_din,
    input  logic                      ready
);

    localparam int         IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam logic       NO_WAIT   = (WAIT_STATES == 0);

    bus_state_t          state_q, state_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]    ptr_q, owner_q, ptr_nxt_s;
    cyc_type_t           cyc_q, cyc_sel_s;
    logic [NUM_REQ-1:0]  gnt_q, gnt_next_s;
    logic [IDX_W-1:0]    win_idx_s;
    logic [ADDR_W-1:0]   addr_q, addr_sel_s;
    logic [DATA_W-1:0]   dout_q, wdata_sel_s, rdata_q;
    logic                done_q, ale_q, rdb_q, wrb_q, doe_q;
    logic                arb_en_s, strobe_d_s;

    assign arb_en_s = (state_q == ST_IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i      (req),
        .ptr_i      (ptr_q),
        .enable_i   (arb_en_s),
        .gnt_next_o (gnt_next_s),
        .winner_o   (win_idx_s)
    );

    // Winner's cycle parameters, selected through the one-hot grant mask
    always_comb begin
        addr_sel_s  = '0;
        wdata_sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_sel_s  = addr_sel_s  | (addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{gnt_next_s[i]}});
            wdata_sel_s = wdata_sel_s | (wdata[i*DATA_W +: DATA_W] & {DATA_W{gnt_next_s[i]}});
        end
        cyc_sel_s = '{iom: |(iom & gnt_next_s), we: |(we & gnt_next_s)};
    end

    assign ptr_nxt_s  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
    assign strobe_d_s = is_strobe_state(state_d);

    // Phase sequencing; the wait counter is armed on the way into T2
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt_next_s) state_d = ST_T1;
                else             state_d = ST_IDLE;
            end
            ST_T1: begin
                state_d    = ST_T2;
                wait_cnt_d = WAIT_INIT;
            end
            ST_T2: begin
                if (NO_WAIT && ready) state_d = ST_T3;
                else                  state_d = ST_TW;
            end
            ST_TW: begin
                // A count of 1 means this TW cycle is the last mandatory one
                if (wait_cnt_q != 4'd0) wait_cnt_d = wait_cnt_q - 4'd1;
                else                    wait_cnt_d = 4'd0;
                if ((wait_cnt_q <= 4'd1) && ready) state_d = ST_T3;
                else                               state_d = ST_TW;
            end
            ST_T3:      state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State, latched cycle parameters and bus outputs registered against the next phase
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            ptr_q      <= '0;
            owner_q    <= '0;
            cyc_q      <= '0;
            gnt_q      <= '0;
            addr_q     <= '0;
            dout_q     <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            ale_q      <= ALE_OFF;
            rdb_q      <= STROBE_OFF;
            wrb_q      <= STROBE_OFF;
            doe_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_q == ST_IDLE && state_d == ST_T1) begin
                gnt_q   <= gnt_next_s;
                owner_q <= win_idx_s;
                cyc_q   <= cyc_sel_s;
                addr_q  <= addr_sel_s;
                dout_q  <= wdata_sel_s;
            end
            if (state_q == ST_RELEASE) begin
                gnt_q <= '0;
                ptr_q <= ptr_nxt_s;
            end
            if (state_q == ST_T3 && !cyc_q.we) begin
                rdata_q <= bus_din;
            end
            ale_q  <= (state_d == ST_T1);
            rdb_q  <= ~(strobe_d_s & ~cyc_q.we);
            wrb_q  <= ~(strobe_d_s & cyc_q.we);
            doe_q  <= strobe_d_s & cyc_q.we;
            done_q <= (state_d == ST_RELEASE);
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign ALE      = ale_q;
    assign rdb      = rdb_q;
    assign wrb      = wrb_q;
    assign IOM      = cyc_q.iom;
    assign bus_addr = addr_q;
    assign bus_dout = dout_q;
    assign bus_doe  = doe_q;

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Bench for bus_cycle_arbiter: a transfer-level reference model checked every
// cycle, plus directed scenarios with hand-computed timing and data.
module tb_bus_cycle_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int WS   = 1;

    logic                 clock;
    logic                 reset;
    logic [NREQ-1:0]      req, we, iom;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ-1:0]      gnt;
    logic                 done;
    logic [DW-1:0]        rdata;
    logic                 ALE, rdb, wrb, IOM, bus_doe;
    logic [AW-1:0]        bus_addr;
    logic [DW-1:0]        bus_dout;
    logic [DW-1:0]        bus_din;
    logic                 ready;

    int n_vec = 0;
    int n_bad = 0;

    bus_cycle_arbiter #(
        .NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .iom(iom),
        .addr(addr), .wdata(wdata), .gnt(gnt), .done(done), .rdata(rdata),
        .ALE(ALE), .rdb(rdb), .wrb(wrb), .IOM(IOM), .bus_addr(bus_addr),
        .bus_dout(bus_dout), .bus_doe(bus_doe), .bus_din(bus_din), .ready(ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: no completion within the cycle budget at t=%0t", nm, $time);
    endtask

    // Reference model: phase 0 idle, 1 address, 2 strobe (T2/TW), 3 last strobe, 4 release
    int            m_ph = 0, m_s = 0, m_ptr = 0, m_owner = 0;
    logic          m_we = 1'b0, m_iom = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;

    task automatic model_step();
        int  c;
        bit  found;
        found = 1'b0;
        if (reset) begin
            m_ph = 0; m_s = 0; m_ptr = 0; m_owner = 0;
            m_we = 1'b0; m_iom = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else begin
            case (m_ph)
                0: for (int k = 0; k < NREQ; k++) begin
                       c = (m_ptr + k) % NREQ;
                       if (!found && req[c]) begin
                           found = 1'b1; m_owner = c; m_we = we[c]; m_iom = iom[c];
                           m_addr = addr[c*AW +: AW]; m_wdata = wdata[c*DW +: DW]; m_ph = 1;
                       end
                   end
                1: begin m_ph = 2; m_s = 0; end
                2: if (m_s >= WS && ready) m_ph = 3; else m_s++;
                3: begin if (!m_we) m_rdata = bus_din; m_ph = 4; end
                default: begin m_ptr = (m_owner + 1) % NREQ; m_ph = 0; end
            endcase
        end
    endtask

    task automatic compare_outputs();
        logic            strobe;
        logic [NREQ-1:0] one, egnt;
        one    = 1;
        strobe = (m_ph == 2) || (m_ph == 3);
        egnt   = (m_ph != 0) ? (one << m_owner) : '0;
        chk("gnt",      gnt,      egnt);
        chk("ALE",      ALE,      m_ph == 1);
        chk("rdb",      rdb,      !(strobe && !m_we));
        chk("wrb",      wrb,      !(strobe && m_we));
        chk("bus_doe",  bus_doe,  strobe && m_we);
        chk("done",     done,     m_ph == 4);
        chk("IOM",      IOM,      m_iom);
        chk("bus_addr", bus_addr, m_addr);
        chk("bus_dout", bus_dout, m_wdata);
        chk("rdata",    rdata,    m_rdata);
        chk("strobes_exclusive", rdb | wrb, 1'b1);
        chk("ale_vs_strobe", ALE & (~rdb | ~wrb), 1'b0);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step();
            #1;
            compare_outputs();
        end
    end

    // Per-cycle samples of one transfer, indexed by cycles since the grant edge
    logic          ale_l [1:40];
    logic          rdb_l [1:40];
    logic          wrb_l [1:40];
    logic          doe_l [1:40];
    logic          iom_l [1:40];
    logic [DW-1:0] dout_l[1:40];

    task automatic xfer(input int r, input logic w, input logic io, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int rl_start, input int rl_len, output int lat);
        @(negedge clock);
        req[r] = 1'b1; we[r] = w; iom[r] = io;
        addr[r*AW +: AW] = a; wdata[r*DW +: DW] = d;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock); #1;
            ale_l[c] = ALE; rdb_l[c] = rdb; wrb_l[c] = wrb;
            doe_l[c] = bus_doe; iom_l[c] = IOM; dout_l[c] = bus_dout;
            if (done) begin lat = c; break; end
            @(negedge clock);
            if (rl_len > 0 && c == rl_start) ready = 1'b0;
            if (rl_len > 0 && c == rl_start + rl_len) ready = 1'b1;
        end
        if (lat == 0) timeout_fail("xfer_done");
        @(negedge clock);
        req[r] = 1'b0;
        ready  = 1'b1;
    endtask

    int              lat;
    int              dn_t[4];
    logic [NREQ-1:0] dn_g[4];
    int              k;

    initial begin
        reset = 1'b1; req = '0; we = '0; iom = '0; addr = '0; wdata = '0;
        bus_din = '0; ready = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Idle after reset
        repeat (10) @(negedge clock);
        chk("t1_ale", ALE, 1'b0);
        chk("t1_rdb", rdb, 1'b1);
        chk("t1_wrb", wrb, 1'b1);
        chk("t1_gnt", gnt, 2'b00);
        chk("t1_done", done, 1'b0);

        // Memory read by requester 0
        bus_din = 8'h5A;
        xfer(0, 1'b0, 1'b0, 16'h2040, 8'h11, 0, 0, lat);
        chk("t2_latency", lat, 32'd5);
        for (int c = 1; c <= 5; c++) begin
            chk("t2_ale", ale_l[c], c == 1);
            chk("t2_rdb", rdb_l[c], !(c >= 2 && c <= 4));
        end
        chk("t2_rdata", rdata, 8'h5A);

        // IO write by requester 1
        bus_din = 8'hEE;
        xfer(1, 1'b1, 1'b1, 16'h0310, 8'hC3, 0, 0, lat);
        chk("t3_latency", lat, 32'd5);
        for (int c = 1; c <= 5; c++) begin
            chk("t3_wrb", wrb_l[c], !(c >= 2 && c <= 4));
            chk("t3_doe", doe_l[c], c >= 2 && c <= 4);
            chk("t3_rdb", rdb_l[c], 1'b1);
            chk("t3_iom", iom_l[c], 1'b1);
            chk("t3_dout", dout_l[c], 8'hC3);
        end
        chk("t3_rdata_held", rdata, 8'h5A);

        // Both requesting continuously: strict alternation, one IDLE between transfers
        @(negedge clock);
        we = '0; iom = '0; addr = {16'hB000, 16'hA000}; req = 2'b11;
        k = 0;
        for (int c = 1; c <= 80 && k < 4; c++) begin
            @(posedge clock); #1;
            if (done) begin dn_t[k] = c; dn_g[k] = gnt; k++; end
        end
        if (k < 4) timeout_fail("t4_four_transfers");
        @(negedge clock);
        req = 2'b00;
        chk("t4_first_done", dn_t[0], 32'd5);
        chk("t4_owner0", dn_g[0], 2'b01);
        chk("t4_owner1", dn_g[1], 2'b10);
        chk("t4_owner2", dn_g[2], 2'b01);
        chk("t4_owner3", dn_g[3], 2'b10);
        for (int i = 0; i < 3; i++) chk("t4_gap", dn_t[i+1] - dn_t[i], 32'd6);

        // Slave holds ready low for three TW cycles
        bus_din = 8'h96;
        xfer(0, 1'b0, 1'b0, 16'h1234, 8'h00, 3, 3, lat);
        chk("t5_latency", lat, 32'd8);
        for (int c = 1; c <= 8; c++) chk("t5_rdb", rdb_l[c], !(c >= 2 && c <= 7));
        chk("t5_rdata", rdata, 8'h96);

        // Reset during TW abandons the transfer and resets the pointer
        @(negedge clock);
        req[1] = 1'b1; we[1] = 1'b0; addr[31:16] = 16'h5555;
        repeat (3) begin @(posedge clock); #1; end
        chk("t6_rdb_in_tw", rdb, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("t6_rdb", rdb, 1'b1);
        chk("t6_gnt", gnt, 2'b00);
        chk("t6_done", done, 1'b0);
        chk("t6_ale", ALE, 1'b0);
        @(negedge clock);
        reset = 1'b0; req = 2'b11;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock); #1;
            if (done) begin lat = c; break; end
        end
        if (lat == 0) timeout_fail("t6_done_after_reset");
        chk("t6_winner", gnt, 2'b01);
        chk("t6_latency", lat, 32'd5);
        @(negedge clock);
        req = 2'b00;
        repeat (3) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
